// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ_SPI read-side scheduler.
package daq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEQ,
    ST_DATA,
    ST_PAD
  } sched_state_t;

  localparam logic [7:0] HDR_BYTE_DFLT = 8'hA5;
  localparam logic [7:0] PAD_BYTE      = 8'h00;

endpackage

// File: rtl/pkg_skid_buf.sv
// Two-entry FIFO holding FIFO words that arrive while the tx slot is occupied.
// The caller's read-credit rule keeps it from overflowing, so no checks here.
module pkg_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] ent0_q;
  logic [DATA_WIDTH-1:0] ent1_q;
  logic [1:0]            count_q;

  assign head  = ent0_q;
  assign count = count_q;

  // Shift-style storage: entry 0 is always the oldest word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= din;
          else                 ent1_q <= din;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          ent0_q  <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_q <= din;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pkg_rd_sched.sv
// Drains one package from ring_fifo and frames it as HDR, SEQ, payload on a
// valid/ready link; pads with zeros if the FIFO starves mid-package.
module pkg_rd_sched
  import daq_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         PKG_SIZE   = 10,
  parameter int         CNT_WIDTH  = 16,
  parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DFLT,
  parameter int         TIMEOUT    = 64
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  enable,
  input  logic                  package_ready,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  fifo_valid,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic [7:0]            pkg_seq,
  output logic                  busy,
  output logic                  underrun,
  input  logic                  clr_err
);

  localparam int                   WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] PKG_CNT  = CNT_WIDTH'(PKG_SIZE);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PKG_SIZE - 1);
  localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TIMEOUT - 1);

  sched_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0]  issued_q, issued_d;
  logic [CNT_WIDTH-1:0]  sent_q, sent_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  abort_q, abort_d;
  logic                  inflight_q;
  logic [7:0]            seq_q, seq_d;
  logic                  underrun_q, set_err;
  logic                  busy_q;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_last_q, tx_last_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

  logic                  buf_push, buf_pop, load_data;
  logic [DATA_WIDTH-1:0] buf_head;
  logic [1:0]            buf_count;
  logic                  have_buf, src_valid, xfer, credit_ok;
  logic [DATA_WIDTH-1:0] src_data;

  pkg_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (buf_push),
    .din   (fifo_dout),
    .pop   (buf_pop),
    .head  (buf_head),
    .count (buf_count)
  );

  assign xfer      = tx_valid_q & tx_ready;
  assign have_buf  = (buf_count != 2'd0);
  assign src_valid = have_buf | fifo_valid;
  assign src_data  = have_buf ? buf_head : fifo_dout;
  // At most two words may be held or outstanding, so the skid buffer never overflows.
  assign credit_ok = (({1'b0, inflight_q} + buf_count) < 2'd2);

  // Read strobe: decoded from registered state plus the live empty flag.
  assign fifo_rd_en = ((state_q == ST_HDR) || (state_q == ST_SEQ) || (state_q == ST_DATA)) &&
                      (issued_q < PKG_CNT) && !fifo_empty && !abort_q && credit_ok;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign pkg_seq  = seq_q;
  assign busy     = busy_q;
  assign underrun = underrun_q;

  // Next-state, counters, watchdog and the next contents of the tx output register.
  always_comb begin
    state_d    = state_q;
    issued_d   = fifo_rd_en ? issued_q + CNT_WIDTH'(1) : issued_q;
    sent_d     = sent_q;
    wd_d       = wd_q;
    abort_d    = abort_q;
    set_err    = 1'b0;
    seq_d      = seq_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    load_data  = 1'b0;

    if ((state_q == ST_DATA) && !abort_q) begin
      if ((issued_q < PKG_CNT) && fifo_empty) begin
        wd_d = wd_q + WD_W'(1);
        if (wd_q == WD_LAST) begin
          abort_d = 1'b1;
          set_err = 1'b1;
        end
      end else begin
        wd_d = '0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && package_ready) begin
          state_d    = ST_HDR;
          tx_valid_d = 1'b1;
          tx_data_d  = DATA_WIDTH'(HDR_BYTE);
          tx_last_d  = 1'b0;
          issued_d   = '0;
          sent_d     = '0;
          wd_d       = '0;
          abort_d    = 1'b0;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          state_d   = ST_SEQ;
          tx_data_d = DATA_WIDTH'(seq_q);
        end
      end
      ST_SEQ: begin
        if (xfer) begin
          state_d = ST_DATA;
          if (src_valid) load_data  = 1'b1;
          else           tx_valid_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (xfer) sent_d = sent_q + CNT_WIDTH'(1);
        if (xfer && tx_last_q) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          seq_d      = seq_q + 8'd1;
        end else if (!tx_valid_q || xfer) begin
          if (src_valid) begin
            load_data = 1'b1;
          end else if (abort_q && !inflight_q) begin
            // Everything fetched has drained; fill the rest of the frame.
            state_d    = ST_PAD;
            tx_valid_d = 1'b1;
            tx_data_d  = DATA_WIDTH'(PAD_BYTE);
            tx_last_d  = (sent_d == LAST_IDX);
          end else begin
            tx_valid_d = 1'b0;
          end
        end
      end
      ST_PAD: begin
        if (xfer) begin
          sent_d = sent_q + CNT_WIDTH'(1);
          if (tx_last_q) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            seq_d      = seq_q + 8'd1;
          end else begin
            tx_last_d = (sent_d == LAST_IDX);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_data) begin
      tx_valid_d = 1'b1;
      tx_data_d  = src_data;
      tx_last_d  = (sent_d == LAST_IDX);
    end

    // Words go straight to the tx register when the buffer is empty and the slot is free.
    buf_pop  = load_data && have_buf;
    buf_push = fifo_valid && !(load_data && !have_buf);
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      issued_q   <= '0;
      sent_q     <= '0;
      wd_q       <= '0;
      abort_q    <= 1'b0;
      inflight_q <= 1'b0;
      seq_q      <= 8'd0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      wd_q       <= wd_d;
      abort_q    <= abort_d;
      inflight_q <= fifo_rd_en;
      seq_q      <= seq_d;
      underrun_q <= set_err ? 1'b1 : (clr_err ? 1'b0 : underrun_q);
      busy_q     <= (state_d != ST_IDLE);
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_last_q  <= tx_last_d;
    end
  end

endmodule

// File: doc/pkg_rd_sched.md
# pkg_rd_sched

Read-side scheduler for the dual-bank `ring_fifo` in the DAQ_SPI path. It waits for a complete package and drains exactly `PKG_SIZE` words with a 1-cycle-latency read handshake. It frames the words as header, sequence number, then payload, and delivers them to the downstream SPI/Wi-Fi byte streamer over a valid/ready interface with full backpressure. It also detects FIFO underrun mid-package and pads the frame so its length on the link never varies.

## Interface
Parameters:
- `DATA_WIDTH`, 8: FIFO word / tx byte width.
- `PKG_SIZE`, 10: payload words per package (production 38912); ≥1.
- `CNT_WIDTH`, 16: width of payload counters; must hold `PKG_SIZE`.
- `HDR_BYTE`, 8'hA5: first byte of every frame.
- `TIMEOUT`, 64: consecutive starved cycles before underrun abort; ≥1.

Ports:
- `sys_clk` in 1: single clock. This is the `ring_fifo` read clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: allows new packages to start.
- `package_ready` in 1: from `ring_fifo`; a full package is available.
- `fifo_empty` in 1: from `ring_fifo`.
- `fifo_rd_en` out 1: read strobe to `ring_fifo`.
- `fifo_valid` in 1: `fifo_dout` is valid; arrives exactly 1 cycle after `fifo_rd_en`.
- `fifo_dout` in `DATA_WIDTH`: FIFO read data.
- `tx_data` out `DATA_WIDTH`: frame byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: downstream accepts; a transfer occurs when `tx_valid & tx_ready`.
- `tx_last` out 1: marks the final payload byte of the frame.
- `pkg_seq` out 8: sequence number of the current or next frame.
- `busy` out 1: high whenever the FSM is not IDLE.
- `underrun` out 1: sticky error flag.
- `clr_err` in 1: synchronous clear of `underrun`.

## Operation
- FSM states: IDLE, HDR, SEQ, DATA, PAD.
- IDLE → HDR when `enable & package_ready`.
  - `enable` dropping mid-frame has no effect; the frame completes, then the FSM stays in IDLE.
- HDR: `tx_data=HDR_BYTE`, `tx_valid=1`. Move to SEQ on transfer.
- SEQ: `tx_data=pkg_seq`. Move to DATA on transfer.
- DATA: `tx_data`/`tx_valid` come from the head of a 2-entry skid buffer.
  - On the transfer of payload byte `PKG_SIZE`, with `tx_last=1`, go to IDLE and increment `pkg_seq` (8-bit wrap: 255→0).
- Read issue (prefetch allowed from HDR onward):
  - `fifo_rd_en=1` iff state ∈ {HDR, SEQ, DATA}, `issued < PKG_SIZE`, `fifo_empty=0`, and `inflight + buffered < 2`.
  - `issued` resets to 0 on IDLE→HDR.
- Underrun watchdog:
  - In DATA, counts consecutive cycles with `issued < PKG_SIZE` and `fifo_empty=1`. Any non-empty cycle resets it.
  - On reaching `TIMEOUT`: set `underrun` and stop issuing reads.
  - Data already buffered or in flight drains normally.
  - When the buffer is empty and nothing is in flight, go to PAD.
- PAD: emits `8'h00` for each remaining payload byte, with `tx_last` on byte `PKG_SIZE`. Then go to IDLE and increment `pkg_seq`.
- Every frame is exactly `PKG_SIZE+2` bytes.
- `underrun` is set and cleared by `clr_err` in the same cycle: set wins.

## Timing
- Reset values:
  - outputs: `fifo_rd_en=0`, `tx_valid=0`, `tx_data=0`, `tx_last=0`, `pkg_seq=0`, `busy=0`, `underrun=0`.
  - internal: FSM in IDLE; buffer, counters and watchdog cleared.
- Reset mid-frame aborts immediately. No frame resumes.
- `package_ready` sampled high in IDLE puts HDR on the link the next cycle, so `tx_valid` is high one cycle after the sample.
- With `tx_ready` held high and the FIFO non-empty:
  - the frame completes in `PKG_SIZE+2` consecutive cycles, with no bubbles;
  - the first `fifo_rd_en` occurs in the first HDR cycle.
- `tx_data`, `tx_valid` and `tx_last` stay stable while `tx_valid & ~tx_ready`.
- `fifo_rd_en` is never high while `fifo_empty=1`.
- `fifo_rd_en` is never high after `PKG_SIZE` reads have issued in a frame.
- The skid buffer never overflows.
- All outputs are registered except `fifo_rd_en`, which may be combinational from registered state and `fifo_empty`.

## Structure
- Shared package `daq_pkg`: FSM state enum, `HDR_BYTE` default, pad value `8'h00`.
- Sub-module `pkg_skid_buf`: 2-entry FIFO with push/pop, `count` output and no overflow checking. The scheduler's credit rule guarantees it never overflows.
- Top module holds the FSM, counters (`issued`, `sent`, watchdog) and the sequence register.

## Test plan
- Nominal, `PKG_SIZE=10`, FIFO preloaded with 0x01..0x0A, `tx_ready=1`: output is A5,00,01..0A over 12 consecutive cycles. `tx_last` on 0x0A. `pkg_seq` becomes 1.
- Backpressure, `tx_ready` toggling 1-0-1-0: the same 12 bytes arrive in order. Outputs stay stable while stalled. Exactly 10 `fifo_rd_en` pulses. The buffer never holds more than 2 entries.
- Underrun, `TIMEOUT=4`: FIFO empties after 6 words. Output is A5,00,01..06 followed by four 00 bytes. `tx_last` on the 12th byte. `underrun=1` until `clr_err`.
- Sequence wrap: run 257 packages. The second byte of each frame goes 00..FF, then 00.
- Control edges: `enable` drops during SEQ, so the frame completes and no new HDR appears. Assert `sys_rst_n=0` mid-DATA, so all outputs go to 0 immediately and the FSM returns to IDLE.
